// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and helpers for the keypad scan controller.
package keypad_pkg;

  localparam int unsigned NUM_ROWS   = 4;
  localparam int unsigned NUM_COLS   = 4;
  localparam int unsigned KEY_CODE_W = 4;
  localparam int unsigned IDX_W      = 2;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    REPORT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  // Lowest pressed row wins when several rows of one column are active.
  function automatic logic [IDX_W-1:0] lowest_row(input logic [NUM_ROWS-1:0] rows);
    lowest_row = '0;
    for (int unsigned i = NUM_ROWS; i > 0; i--) begin
      if (rows[i-1]) lowest_row = IDX_W'(i - 1);
    end
  endfunction

  function automatic logic [NUM_COLS-1:0] onehot_col(input logic [IDX_W-1:0] idx);
    onehot_col      = '0;
    onehot_col[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key event valid/ready channel between the scan controller and its consumer.
interface keypad_scan_ctrl_if;
  import keypad_pkg::*;

  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_ctrl_tick.sv
// Free-running divider producing a one-cycle scan tick every TICK_DIV clocks.
module scan_tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV - 1) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, row sync, debounce, valid/ready key events.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned DB_TICKS = 20
`ifdef KEYPAD_REPEAT_EN
  , parameter int unsigned REPEAT_TICKS = 500
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic                busy,
  keypad_scan_ctrl_if.master  key_if
);

  localparam int unsigned DB_W = $clog2(DB_TICKS) + 1;

  logic                  tick;
  logic [NUM_ROWS-1:0]   row_m_q, row_s_q;
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      col_idx_q, col_idx_d;
  logic [NUM_ROWS-1:0]   cand_row_q, cand_row_d;
  logic [DB_W-1:0]       db_cnt_q, db_cnt_d;
  logic [DB_W-1:0]       rel_cnt_q, rel_cnt_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned HOLD_W = $clog2(REPEAT_TICKS) + 1;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
`endif

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_m_q <= '0;
      row_s_q <= '0;
    end else begin
      row_m_q <= row_in;
      row_s_q <= row_m_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= SCAN;
      col_idx_q  <= '0;
      cand_row_q <= '0;
      db_cnt_q   <= '0;
      rel_cnt_q  <= '0;
      key_code_q <= '0;
`ifdef KEYPAD_REPEAT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      cand_row_q <= cand_row_d;
      db_cnt_q   <= db_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      key_code_q <= key_code_d;
`ifdef KEYPAD_REPEAT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    cand_row_d = cand_row_q;
    db_cnt_d   = db_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    key_code_d = key_code_q;
`ifdef KEYPAD_REPEAT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (tick) begin
          if (row_s_q == '0) begin
            col_idx_d = col_idx_q + 1'b1;
          end else begin
            cand_row_d = row_s_q;
            db_cnt_d   = DB_W'(1);
            // The detecting tick already counts as the first stable sample.
            if (DB_TICKS == 1) begin
              key_code_d = {col_idx_q, lowest_row(row_s_q)};
              state_d    = REPORT;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (row_s_q == cand_row_q) begin
            db_cnt_d = db_cnt_q + 1'b1;
            if (db_cnt_q == DB_W'(DB_TICKS - 1)) begin
              key_code_d = {col_idx_q, lowest_row(cand_row_q)};
              state_d    = REPORT;
            end
          end else begin
            state_d = SCAN;
          end
        end
      end
      REPORT: begin
        if (key_if.key_ready) begin
          state_d   = WAIT_RELEASE;
          rel_cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      WAIT_RELEASE: begin
        if (tick) begin
          if (row_s_q == '0) begin
            if (rel_cnt_q == DB_W'(DB_TICKS - 1)) begin
              rel_cnt_d = '0;
              col_idx_d = col_idx_q + 1'b1;
              state_d   = SCAN;
            end else begin
              rel_cnt_d = rel_cnt_q + 1'b1;
            end
          end else begin
            rel_cnt_d = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (row_s_q == cand_row_q) begin
            if (hold_cnt_q == HOLD_W'(REPEAT_TICKS - 1)) begin
              hold_cnt_d = '0;
              state_d    = REPORT;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end else begin
            hold_cnt_d = '0;
          end
`endif
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    col_out          = onehot_col(col_idx_q);
    busy             = (state_q != SCAN);
    key_if.key_valid = (state_q == REPORT);
    key_if.key_code  = key_code_q;
  end

endmodule
